// File: rtl/spi_pkg.sv
// spi_pkg: shared constants, FSM state type and width helpers for the SPI slave.
package spi_pkg;
   localparam int SPI_MAX_W = 32;
   typedef enum logic {IDLE, SHIFT} spi_state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction
   function automatic int lvl_w(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/spi_slave_fifo_if.sv
// spi_slave_fifo_if: SPI pins plus the user-side TX/RX/status bus of the SPI slave.
interface spi_slave_fifo_if #(parameter int DATA_W = 16, parameter int DEPTH = 4);
   import spi_pkg::*;
   logic spi_cs_n, mosi, miso;
   logic [DATA_W-1:0] tx_data, rx_data;
   logic tx_valid, tx_ready, rx_valid, rx_ready, err_clr;
   logic [lvl_w(DEPTH)-1:0] rx_level;
   logic rx_overflow, tx_underflow, frame_abort;
   logic [cnt_w(DATA_W)-1:0] bit_cnt;
   modport slave (
      input  spi_cs_n, mosi, tx_data, tx_valid, rx_ready, err_clr,
      output miso, tx_ready, rx_data, rx_valid, rx_level, rx_overflow, tx_underflow, frame_abort, bit_cnt
   );
   modport master (
      output spi_cs_n, mosi, tx_data, tx_valid, rx_ready, err_clr,
      input  miso, tx_ready, rx_data, rx_valid, rx_level, rx_overflow, tx_underflow, frame_abort, bit_cnt
   );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous FIFO for received words; push is accepted when full only with a same-edge pop.
module spi_rx_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     spi_sclk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [lvl_w(DEPTH)-1:0]  level
);
   localparam int AW = cnt_w(DEPTH);
   localparam int LW = AW + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   // DEPTH is a power of two, so the top level bit alone marks full
   assign full    = level[AW];
   assign empty   = level == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge spi_sclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
   always_ff @(posedge spi_sclk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end
endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: parametrised full-duplex SPI slave with a TX holding register,
// an RX FIFO and sticky overflow/underflow/abort flags, all on spi_sclk.
module spi_slave_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1
) (
   input logic             spi_sclk,
   input logic             rst,
   spi_slave_fifo_if.slave bus
);
   localparam int CW = cnt_w(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   if (DATA_W < 4 || DATA_W > SPI_MAX_W) begin : g_bad_w
      $error("spi_slave_fifo: DATA_W out of range");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_d
      $error("spi_slave_fifo: DEPTH must be a power of two >= 2");
   end
   spi_state_t state, state_d;
   logic [CW-1:0] bit_cnt, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift, rx_shift_d, rx_word, tx_shift, tx_shift_d, hold;
   logic hold_full, hold_full_d, boundary, accept, abort, underflow, overflow;
   logic rx_overflow, tx_underflow, frame_abort, fifo_full, fifo_empty;
   always_ff @(posedge spi_sclk) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         rx_overflow  <= 1'b0;
         tx_underflow <= 1'b0;
         frame_abort  <= 1'b0;
      end else begin
         state        <= state_d;
         bit_cnt      <= bit_cnt_d;
         rx_shift     <= rx_shift_d;
         tx_shift     <= tx_shift_d;
         hold         <= accept ? bus.tx_data : hold;
         hold_full    <= hold_full_d;
         rx_overflow  <= (rx_overflow && !bus.err_clr) || overflow;
         tx_underflow <= (tx_underflow && !bus.err_clr) || underflow;
         frame_abort  <= (frame_abort && !bus.err_clr) || abort;
      end
   end
   // Chip select on the current edge decides the state; boundaries are handled inside SHIFT
   always_comb begin
      state_d     = bus.spi_cs_n ? IDLE : SHIFT;
      boundary    = state_d == SHIFT && bit_cnt == LAST;
      abort       = state_d == IDLE && state == SHIFT && bit_cnt != '0;
      accept      = bus.tx_valid && !hold_full;
      underflow   = boundary && !hold_full;
      overflow    = boundary && fifo_full && !bus.rx_ready;
      rx_word     = MSB_FIRST ? {rx_shift[DATA_W-2:0], bus.mosi} : {bus.mosi, rx_shift[DATA_W-1:1]};
      bit_cnt_d   = (state_d == SHIFT && !boundary) ? bit_cnt + 1'b1 : '0;
      rx_shift_d  = state_d == SHIFT ? rx_word : rx_shift;
      tx_shift_d  = boundary ? (hold_full ? hold : '0)
                  : state_d == SHIFT ? (MSB_FIRST ? tx_shift << 1 : tx_shift >> 1)
                  : hold_full ? hold : tx_shift;
      // A consume (boundary or idle reload) always sees the old contents; a new accept wins afterwards
      hold_full_d = accept || (hold_full && state_d == SHIFT && !boundary);
   end
   spi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .spi_sclk (spi_sclk),
      .rst      (rst),
      .push     (boundary),
      .pop      (bus.rx_ready),
      .din      (rx_word),
      .dout     (bus.rx_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (bus.rx_level)
   );
   assign bus.miso         = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
   assign bus.tx_ready     = !hold_full;
   assign bus.rx_valid     = !fifo_empty;
   assign bus.bit_cnt      = bit_cnt;
   assign bus.rx_overflow  = rx_overflow;
   assign bus.tx_underflow = tx_underflow;
   assign bus.frame_abort  = frame_abort;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed bench with an RX scoreboard for a 16-bit MSB-first
// instance and direct checks for an 8-bit LSB-first instance.
module tb_spi_slave_fifo;
   logic spi_sclk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];
   logic [15:0] tx_pat, rx_pat;
   logic [7:0] tx8, rx8;
   spi_slave_fifo_if #(.DATA_W(16), .DEPTH(4)) b16 ();
   spi_slave_fifo_if #(.DATA_W(8), .DEPTH(4)) b8 ();
   spi_slave_fifo #(.DATA_W(16), .DEPTH(4), .MSB_FIRST(1)) u16 (
      .spi_sclk (spi_sclk),
      .rst      (rst),
      .bus      (b16.slave)
   );
   spi_slave_fifo #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(0)) u8 (
      .spi_sclk (spi_sclk),
      .rst      (rst),
      .bus      (b8.slave)
   );
   always #5 spi_sclk = ~spi_sclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge spi_sclk);
      #1;
   endtask

   // Monitor: samples just before the rising edge that performs the pop
   always @(negedge spi_sclk) begin
      #3;
      if (!rst && b16.rx_valid && b16.rx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_pop: unexpected word %0h", b16.rx_data);
         end else check("rx_pop", b16.rx_data, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      b16.spi_cs_n = 1; b16.mosi = 0; b16.tx_data = 0; b16.tx_valid = 0; b16.rx_ready = 0; b16.err_clr = 0;
      b8.spi_cs_n = 1; b8.mosi = 0; b8.tx_data = 0; b8.tx_valid = 0; b8.rx_ready = 0; b8.err_clr = 0;
      cyc(); cyc();
      rst = 0;
      check("rst_miso", b16.miso, 0);
      check("rst_tx_ready", b16.tx_ready, 1);
      check("rst_rx_valid", b16.rx_valid, 0);
      check("rst_rx_level", b16.rx_level, 0);
      check("rst_rx_data", b16.rx_data, 0);
      check("rst_bit_cnt", b16.bit_cnt, 0);
      check("rst_flags", {b16.rx_overflow, b16.tx_underflow, b16.frame_abort}, 0);
      // Preload A5C3, receive 1234, queue 0F0F for the next word mid-frame
      b16.tx_data = 16'hA5C3; b16.tx_valid = 1; cyc();
      b16.tx_valid = 0;
      check("a_hold_full", b16.tx_ready, 0);
      cyc();
      check("a_hold_moved", b16.tx_ready, 1);
      tx_pat = 16'hA5C3; rx_pat = 16'h1234;
      exp_q.push_back(rx_pat);
      b16.spi_cs_n = 0;
      for (int i = 0; i < 16; i++) begin
         b16.mosi = rx_pat[15-i];
         b16.tx_valid = i == 2; b16.tx_data = 16'h0F0F;
         check("a_miso", b16.miso, tx_pat[15-i]);
         cyc();
      end
      b16.tx_valid = 0; b16.spi_cs_n = 1;
      cyc();
      check("a_rx_level", b16.rx_level, 1);
      check("a_rx_data", b16.rx_data, 16'h1234);
      check("a_rx_valid", b16.rx_valid, 1);
      check("a_underflow", b16.tx_underflow, 0);
      check("a_abort", b16.frame_abort, 0);
      check("a_next_miso", b16.miso, 0);
      b16.rx_ready = 1; cyc(); b16.rx_ready = 0;
      check("b_empty", b16.rx_level, 0);
      // Five words into a 4-deep FIFO: the fifth is dropped
      b16.spi_cs_n = 0;
      for (int w = 1; w <= 5; w++) begin
         rx_pat = 16'(w * 'h1111);
         if (w < 5) exp_q.push_back(rx_pat);
         for (int i = 0; i < 16; i++) begin
            b16.mosi = rx_pat[15-i];
            cyc();
         end
      end
      check("b_level_full", b16.rx_level, 4);
      check("b_overflow", b16.rx_overflow, 1);
      check("b_head", b16.rx_data, 16'h1111);
      b16.spi_cs_n = 1; b16.err_clr = 1; cyc(); b16.err_clr = 0;
      check("b_overflow_clr", b16.rx_overflow, 0);
      check("b_underflow_clr", b16.tx_underflow, 0);
      // Push and pop on the same edge while full
      rx_pat = 16'h6666;
      exp_q.push_back(rx_pat);
      b16.spi_cs_n = 0;
      for (int i = 0; i < 16; i++) begin
         b16.mosi = rx_pat[15-i];
         b16.rx_ready = i == 15;
         cyc();
      end
      b16.rx_ready = 0; b16.spi_cs_n = 1;
      check("b_full_pushpop_level", b16.rx_level, 4);
      check("b_full_pushpop_ovf", b16.rx_overflow, 0);
      check("b_full_pushpop_head", b16.rx_data, 16'h2222);
      b16.rx_ready = 1; repeat (4) cyc(); b16.rx_ready = 0;
      check("b_drained", b16.rx_level, 0);
      // Abort after 7 bits, then a clean word
      b16.spi_cs_n = 0; b16.mosi = 1;
      repeat (7) cyc();
      check("c_bit_cnt7", b16.bit_cnt, 7);
      b16.spi_cs_n = 1; cyc();
      check("c_abort", b16.frame_abort, 1);
      check("c_bit_cnt0", b16.bit_cnt, 0);
      check("c_no_push", b16.rx_level, 0);
      rx_pat = 16'hBEEF;
      exp_q.push_back(rx_pat);
      b16.spi_cs_n = 0;
      for (int i = 0; i < 16; i++) begin
         b16.mosi = rx_pat[15-i];
         cyc();
      end
      b16.spi_cs_n = 1; cyc();
      check("c_level", b16.rx_level, 1);
      b16.rx_ready = 1; cyc(); b16.rx_ready = 0;
      b16.err_clr = 1; cyc(); b16.err_clr = 0;
      check("c_abort_clr", b16.frame_abort, 0);
      check("c_underflow_clr", b16.tx_underflow, 0);
      // Underflow on the second word, then accept on the following boundary
      b16.tx_data = 16'h6A6A; b16.tx_valid = 1; cyc();
      b16.tx_valid = 0; cyc();
      check("d_underflow_pre", b16.tx_underflow, 0);
      tx_pat = 16'h6A6A;
      b16.spi_cs_n = 0;
      for (int w = 1; w <= 2; w++) begin
         rx_pat = 16'(w);
         exp_q.push_back(rx_pat);
         for (int i = 0; i < 16; i++) begin
            b16.mosi = rx_pat[15-i];
            check("d_miso", b16.miso, w == 1 ? tx_pat[15-i] : 1'b0);
            if (w == 2 && i == 15) begin
               b16.tx_valid = 1; b16.tx_data = 16'hC0DE;
            end
            cyc();
         end
         if (w == 1) check("d_underflow", b16.tx_underflow, 1);
      end
      b16.tx_valid = 0;
      check("d_accept_on_boundary", b16.tx_ready, 0);
      check("d_miso_empty_word", b16.miso, 0);
      b16.spi_cs_n = 1; cyc();
      check("d_idle_reload", b16.tx_ready, 1);
      check("d_idle_reload_miso", b16.miso, 1);
      b16.rx_ready = 1; repeat (2) cyc(); b16.rx_ready = 0;
      // Reset mid-word at bit 9 with a non-empty FIFO
      rx_pat = 16'h7777;
      b16.spi_cs_n = 0;
      for (int i = 0; i < 16; i++) begin
         b16.mosi = rx_pat[15-i];
         b16.tx_valid = i == 2; b16.tx_data = 16'hFFFF;
         cyc();
      end
      b16.tx_valid = 0; b16.mosi = 0;
      repeat (9) cyc();
      check("e_pre_level", b16.rx_level, 1);
      check("e_pre_miso", b16.miso, 1);
      check("e_pre_bit_cnt", b16.bit_cnt, 9);
      rst = 1; cyc();
      check("e_bit_cnt", b16.bit_cnt, 0);
      check("e_miso", b16.miso, 0);
      check("e_rx_valid", b16.rx_valid, 0);
      check("e_rx_level", b16.rx_level, 0);
      check("e_rx_data", b16.rx_data, 0);
      check("e_tx_ready", b16.tx_ready, 1);
      check("e_flags", {b16.rx_overflow, b16.tx_underflow, b16.frame_abort}, 0);
      rst = 0; b16.spi_cs_n = 1;
      // 8-bit LSB-first: transmit 3C, receive 81
      b8.tx_data = 8'h3C; b8.tx_valid = 1; cyc();
      b8.tx_valid = 0; cyc();
      tx8 = 8'h3C; rx8 = 8'h81;
      b8.spi_cs_n = 0;
      for (int i = 0; i < 8; i++) begin
         b8.mosi = rx8[i];
         check("f_miso", b8.miso, tx8[i]);
         cyc();
      end
      b8.spi_cs_n = 1; cyc();
      check("f_rx_data", b8.rx_data, 8'h81);
      check("f_rx_level", b8.rx_level, 1);
      check("f_bit_cnt", b8.bit_cnt, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
